// File: rtl/frame_stream_reader.sv
// frame_stream_reader
//   Consumer end of the 17-bit pixel queue. Pops words from the queue FIFO,
//   decodes frame/row markers and emits RGB565 pixels with x/y coordinates on
//   a valid/ready stream. Pulses frame_start, frame_done and frame_error.
//
// Ports
//   clk          single clock, also drives the FIFO read port
//   reset_n      synchronous active-low reset
//   queue_empty  FIFO empty flag
//   queue_data   FIFO read data, valid the cycle after queue_rd_en
//   queue_rd_en  FIFO pop request
//   pixel_ready  downstream accepts pixel
//   pixel_valid  pixel output valid
//   pixel_data   RGB565 pixel
//   pixel_x      column of pixel_data
//   pixel_y      row of pixel_data
//   frame_start  one-cycle pulse, frame-start marker consumed
//   frame_done   one-cycle pulse, frame completed
//   frame_error  one-cycle pulse, protocol violation
module frame_stream_reader #(
  parameter int unsigned FRAME_WIDTH       = 480,
  parameter int unsigned FRAME_HEIGHT      = 272,
  parameter logic        EXPECT_EXTRA_DATA = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        queue_empty,
  input  logic [16:0] queue_data,
  output logic        queue_rd_en,
  input  logic        pixel_ready,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_error
);

  localparam logic [16:0] WORD_FRAME_START = 17'h10000;
  localparam logic [16:0] WORD_ROW_START   = 17'h10001;
  localparam logic [16:0] WORD_FRAME_END   = 17'h1FFFF;
  localparam logic [10:0] LAST_X           = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0] LAST_Y           = 11'(FRAME_HEIGHT - 1);
  localparam logic [10:0] HEIGHT           = 11'(FRAME_HEIGHT);

  typedef enum logic [1:0] {
    ST_WAIT_FRAME,
    ST_WAIT_ROW,
    ST_PIXELS,
    ST_WAIT_END
  } state_e;

  state_e      state_q;
  logic [10:0] x_q, y_q;

  // Two-entry word buffer plus the word currently in flight from the FIFO.
  logic [16:0] buf0_q, buf1_q, buf0_d, buf1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        inflight_q;

  logic        pixel_valid_q;
  logic [15:0] pixel_data_q;
  logic [10:0] pixel_x_q, pixel_y_q;
  logic        frame_start_q, frame_done_q, frame_error_q;
  // Output register holds the final pixel of a marker-less frame.
  logic        last_q;

  logic        head_valid;
  logic [16:0] head;
  logic        head_is_pixel;
  logic        out_free;
  logic        pop;
  logic [2:0]  occupancy;

  // When the buffer is empty the arriving FIFO word is consumed directly,
  // giving rd_en -> pixel_valid in two cycles.
  always_comb begin
    head_valid    = (cnt_q != 2'd0) || inflight_q;
    head          = (cnt_q != 2'd0) ? buf0_q : queue_data;
    head_is_pixel = !head[16];
    out_free      = !pixel_valid_q || pixel_ready;
    pop           = head_valid && (!head_is_pixel || out_free);
    occupancy     = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    queue_rd_en   = reset_n && !queue_empty && (occupancy < 3'd2);
  end

  // Shift out the popped entry, then append the arriving word unless it was
  // consumed on the bypass path.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    if (pop && (cnt_q != 2'd0)) begin
      buf0_d = buf1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (inflight_q && !(pop && (cnt_q == 2'd0))) begin
      if (cnt_d == 2'd0) begin
        buf0_d = queue_data;
      end else begin
        buf1_d = queue_data;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_WAIT_FRAME;
      x_q           <= '0;
      y_q           <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      cnt_q         <= '0;
      inflight_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      inflight_q    <= queue_rd_en;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      cnt_q         <= cnt_d;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;

      if (pixel_valid_q && pixel_ready) begin
        pixel_valid_q <= 1'b0;
        last_q        <= 1'b0;
      end

      if (pop) begin
        if (head == WORD_FRAME_START) begin
          // Resynchronise from any state; outside WAIT_FRAME it aborts a frame.
          frame_start_q <= 1'b1;
          frame_error_q <= (state_q != ST_WAIT_FRAME);
          x_q           <= '0;
          y_q           <= '0;
          state_q       <= EXPECT_EXTRA_DATA ? ST_WAIT_ROW : ST_PIXELS;
        end else begin
          case (state_q)
            ST_WAIT_FRAME: ;  // everything else is dropped silently

            ST_WAIT_ROW: begin
              if (head == WORD_ROW_START) begin
                state_q <= ST_PIXELS;
                x_q     <= '0;
              end else if (head == WORD_FRAME_END) begin
                frame_done_q  <= 1'b1;
                frame_error_q <= (y_q < HEIGHT);
                state_q       <= ST_WAIT_FRAME;
              end else begin
                frame_error_q <= 1'b1;
              end
            end

            ST_PIXELS: begin
              if (head_is_pixel) begin
                pixel_valid_q <= 1'b1;
                pixel_data_q  <= head[15:0];
                pixel_x_q     <= x_q;
                pixel_y_q     <= y_q;
                if (x_q == LAST_X) begin
                  x_q <= '0;
                  y_q <= y_q + 11'd1;
                  if (y_q == LAST_Y) begin
                    if (EXPECT_EXTRA_DATA) begin
                      state_q <= ST_WAIT_END;
                    end else begin
                      state_q <= ST_WAIT_FRAME;
                      last_q  <= 1'b1;
                    end
                  end else if (EXPECT_EXTRA_DATA) begin
                    state_q <= ST_WAIT_ROW;
                  end
                end else begin
                  x_q <= x_q + 11'd1;
                end
              end else if (head == WORD_ROW_START) begin
                if (x_q != 11'd0) begin
                  frame_error_q <= 1'b1;
                  y_q           <= y_q + 11'd1;
                  x_q           <= '0;
                end
              end else if (head == WORD_FRAME_END) begin
                frame_done_q  <= 1'b1;
                frame_error_q <= 1'b1;
                state_q       <= ST_WAIT_FRAME;
              end else begin
                frame_error_q <= 1'b1;
              end
            end

            ST_WAIT_END: begin
              if (head == WORD_FRAME_END) begin
                frame_done_q <= 1'b1;
                state_q      <= ST_WAIT_FRAME;
              end else begin
                frame_error_q <= 1'b1;
              end
            end

            default: state_q <= ST_WAIT_FRAME;
          endcase
        end
      end
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;
  assign frame_error = frame_error_q;
  // Without markers the frame ends with the handshake of its last pixel.
  assign frame_done  = frame_done_q || (last_q && pixel_valid_q && pixel_ready);

endmodule
